// File: rtl/wide_lut_ram_pkg.sv
// Shared constants and chunk-layout helpers for the wide LUT RAM.
// Word layout: ceil(WIDTH/16) chunks packed into a power-of-two stride.
package wide_lut_ram_pkg;

  localparam int CHUNK_W = 16;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;

  function automatic int n_chunks(input int width);
    return (width + CHUNK_W - 1) / CHUNK_W;
  endfunction

  function automatic int chunk_stride(input int width);
    int s;
    s = 1;
    while (s < n_chunks(width)) s = s * 2;
    return s;
  endfunction

endpackage

// File: rtl/dual_port_lut_mem.sv
// Word memory with a prioritised user write port and a bus commit port.
// User read is registered read-first; the bus read is combinational.
module dual_port_lut_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    u_addr,
  input  logic [WIDTH-1:0] u_din,
  input  logic             u_we,
  output logic [WIDTH-1:0] u_dout,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_din,
  input  logic             b_we,
  output logic [WIDTH-1:0] b_dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] dout_q;
  logic             b_win;

  always_comb begin
    dout_d = mem[u_addr];
    b_win  = b_we && !(u_we && (u_addr == b_addr));
  end

  always_ff @(posedge clk) begin
    if (b_win) mem[b_addr] <= b_din;
    if (u_we) mem[u_addr] <= u_din;
  end

  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign u_dout = dout_q;
  assign b_dout = mem[b_addr];

endmodule

// File: rtl/wide_lut_ram.sv
// Bus-attached wide LUT RAM: chunked bus access with staged atomic
// commits and snapshot reads, plus a direct user port.
module wide_lut_ram
  import wide_lut_ram_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int BASE_ADDR  = 0,
  parameter int BUS_WRITE  = 1,
  parameter int USER_WRITE = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rw_i,
  input  logic              valid_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rw_o,
  output logic              valid_o,
  input  logic [AW-1:0]     user_addr,
  input  logic [WIDTH-1:0]  user_din,
  input  logic              user_we,
  output logic [WIDTH-1:0]  user_dout
);

  localparam int N      = n_chunks(WIDTH);
  localparam int STRIDE = chunk_stride(WIDTH);
  localparam int SW     = $clog2(STRIDE);
  localparam int CW     = (SW > 0) ? SW : 1;
  localparam int SPAN   = DEPTH * STRIDE;
  localparam int PW     = N * CHUNK_W;
  localparam int SN     = (N > 1) ? N - 1 : 1;

  logic [ADDR_W-1:0]    addr_d, addr_q;
  logic [DATA_W-1:0]    wdata_d, wdata_q;
  logic [DATA_W-1:0]    rdata_d, rdata_q;
  logic                 rw_d, rw_q;
  logic                 valid_d, valid_q;
  logic [SN*CHUNK_W-1:0] stg_d, stg_q;
  logic [PW-1:0]        snap_d, snap_q;

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [AW-1:0]     word;
  logic [CW-1:0]     chunk;
  logic [WIDTH-1:0]  rd_word;
  logic [PW-1:0]     rd_pad;
  logic [WIDTH-1:0]  b_din;
  logic              b_we;
  logic              u_we;

  always_comb begin
    offset   = addr_i - ADDR_W'(BASE_ADDR);
    in_range = valid_i && !rst
            && (int'(addr_i) >= BASE_ADDR)
            && (int'(addr_i) < BASE_ADDR + SPAN);
    word     = AW'(offset >> SW);
    chunk    = CW'(offset) & CW'(STRIDE - 1);
    rd_pad   = PW'(rd_word);
    u_we     = user_we && (USER_WRITE != 0);
    b_din    = (N == 1) ? WIDTH'(wdata_i)
                        : WIDTH'({wdata_i, stg_q});
  end

  always_comb begin
    addr_d  = addr_i;
    wdata_d = wdata_i;
    rdata_d = rdata_i;
    rw_d    = rw_i;
    valid_d = valid_i;
    stg_d   = stg_q;
    snap_d  = snap_q;
    b_we    = 1'b0;
    if (in_range && !rw_i) begin
      if (chunk == '0) begin
        rdata_d = rd_pad[CHUNK_W-1:0];
        snap_d  = rd_pad;
      end else if (int'(chunk) < N) begin
        rdata_d = snap_q[int'(chunk)*CHUNK_W +: CHUNK_W];
      end else begin
        rdata_d = '0;
      end
    end
    if (in_range && rw_i && (BUS_WRITE != 0)) begin
      if (int'(chunk) == N - 1)
        b_we = 1'b1;
      else if (int'(chunk) < N - 1)
        stg_d[int'(chunk)*CHUNK_W +: CHUNK_W] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      stg_q   <= '0;
      snap_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      stg_q   <= stg_d;
      snap_q  <= snap_d;
    end
  end

  dual_port_lut_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .u_addr (user_addr),
    .u_din  (user_din),
    .u_we   (u_we),
    .u_dout (user_dout),
    .b_addr (word),
    .b_din  (b_din),
    .b_we   (b_we),
    .b_dout (rd_word)
  );

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_wide_lut_ram.sv
// Scoreboard bench: a bus-writable and a bus-read-only instance share
// stimulus; a word-level model predicts every cycle's outputs.
module tb_wide_lut_ram;

  localparam int W    = 40;
  localparam int D    = 8;
  localparam int BASE = 256;

  typedef struct packed {
    logic [15:0]       addr;
    logic [15:0]       wdata;
    logic              rw;
    logic              valid;
    logic [1:0][15:0]  rdata;
    logic [1:0][39:0]  ud;
    logic [1:0]        rd_chk;
    logic [1:0]        ud_chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_i, wdata_i, rdata_i;
  logic        rw_i, valid_i;
  logic [2:0]  user_addr;
  logic [39:0] user_din;
  logic        user_we;

  logic [15:0] addr_o [2];
  logic [15:0] wdata_o [2];
  logic [15:0] rdata_o [2];
  logic        rw_o [2];
  logic        valid_o [2];
  logic [39:0] user_dout [2];

  exp_t        q [$];
  int          checks = 0;
  int          errors = 0;

  logic [39:0] mem_m [2][D];
  bit          known [2][D];
  logic [15:0] stg_m [2][2];
  logic [47:0] snap_m [2];
  bit          snap_known [2];
  logic [39:0] init_val [D];

  always #5 clk = ~clk;

  wide_lut_ram #(
    .WIDTH(W), .DEPTH(D), .BASE_ADDR(BASE),
    .BUS_WRITE(1), .USER_WRITE(1)
  ) u_rw (
    .clk(clk), .rst(rst),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
    .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o[0]), .wdata_o(wdata_o[0]), .rdata_o(rdata_o[0]),
    .rw_o(rw_o[0]), .valid_o(valid_o[0]),
    .user_addr(user_addr), .user_din(user_din),
    .user_we(user_we), .user_dout(user_dout[0])
  );

  wide_lut_ram #(
    .WIDTH(W), .DEPTH(D), .BASE_ADDR(BASE),
    .BUS_WRITE(0), .USER_WRITE(1)
  ) u_ro (
    .clk(clk), .rst(rst),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
    .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o[1]), .wdata_o(wdata_o[1]), .rdata_o(rdata_o[1]),
    .rw_o(rw_o[1]), .valid_o(valid_o[1]),
    .user_addr(user_addr), .user_din(user_din),
    .user_we(user_we), .user_dout(user_dout[1])
  );

  task automatic chk(input string nm, input int inst,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h at %0t",
               nm, inst, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] rd,
                      input bit rw, input bit v,
                      input logic [2:0] ua, input logic [39:0] ud,
                      input bit uwe);
    exp_t e;
    int off, wi, ch;
    bit inr, cw;
    logic [39:0] cv;
    rst = r; addr_i = a; wdata_i = wd; rdata_i = rd;
    rw_i = rw; valid_i = v;
    user_addr = ua; user_din = ud; user_we = uwe;
    e = '0;
    e.addr  = r ? 16'h0 : a;
    e.wdata = r ? 16'h0 : wd;
    e.rw    = r ? 1'b0 : rw;
    e.valid = r ? 1'b0 : v;
    for (int i = 0; i < 2; i++) begin
      e.rd_chk[i] = 1'b1;
      if (r) begin
        e.rdata[i] = '0;
        e.ud[i] = '0;
        e.ud_chk[i] = 1'b1;
        stg_m[i][0] = '0;
        stg_m[i][1] = '0;
        snap_m[i] = '0;
        snap_known[i] = 1'b1;
        continue;
      end
      e.ud[i] = mem_m[i][ua];
      e.ud_chk[i] = known[i][ua];
      e.rdata[i] = rd;
      off = int'(a) - BASE;
      inr = v && off >= 0 && off < D * 4;
      wi = inr ? off / 4 : 0;
      ch = inr ? off % 4 : 0;
      cw = 1'b0;
      cv = '0;
      if (inr && !rw) begin
        if (ch == 0) begin
          e.rdata[i] = mem_m[i][wi][15:0];
          e.rd_chk[i] = known[i][wi];
          snap_m[i] = {8'h0, mem_m[i][wi]};
          snap_known[i] = known[i][wi];
        end else if (ch < 3) begin
          e.rdata[i] = snap_m[i][ch*16 +: 16];
          e.rd_chk[i] = snap_known[i];
        end else begin
          e.rdata[i] = '0;
        end
      end
      if (inr && rw && i == 0) begin
        if (ch < 2) stg_m[i][ch] = wd;
        else if (ch == 2) begin
          cw = 1'b1;
          cv = {wd[7:0], stg_m[i][1], stg_m[i][0]};
        end
      end
      if (cw) begin
        mem_m[i][wi] = cv;
        known[i][wi] = 1'b1;
      end
      if (uwe) begin
        mem_m[i][ua] = ud;
        known[i][ua] = 1'b1;
      end
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic bus(input logic [15:0] a, input logic [15:0] wd,
                     input bit rw, input logic [2:0] ua);
    step(0, a, wd, 16'h0, rw, 1, ua, '0, 0);
  endtask

  task automatic idle(input logic [2:0] ua);
    step(0, 16'h0, 16'h0, 16'h0, 0, 0, ua, '0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk("addr_o", i, 64'(addr_o[i]), 64'(e.addr));
          chk("wdata_o", i, 64'(wdata_o[i]), 64'(e.wdata));
          chk("rw_o", i, 64'(rw_o[i]), 64'(e.rw));
          chk("valid_o", i, 64'(valid_o[i]), 64'(e.valid));
          if (e.rd_chk[i])
            chk("rdata_o", i, 64'(rdata_o[i]), 64'(e.rdata[i]));
          if (e.ud_chk[i])
            chk("user_dout", i, 64'(user_dout[i]), 64'(e.ud[i]));
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < D; w++) known[i][w] = 1'b0;
    step(1, 16'h0, 16'h0, 16'h0, 0, 0, 3'd0, '0, 0);
    step(1, 16'h0, 16'h0, 16'h0, 0, 0, 3'd0, '0, 0);
    for (int w = 0; w < D; w++) begin
      init_val[w] = {8'($urandom), 32'($urandom)};
      step(0, 16'h0, 16'h0, 16'h0, 0, 0, 3'(w), init_val[w], 1);
    end

    bus(16'h100, 16'h1111, 1, 3'd0);
    bus(16'h101, 16'h2222, 1, 3'd0);
    idle(3'd0);
    chk("s1_pre", 0, 64'(user_dout[0]), 64'(init_val[0]));
    bus(16'h102, 16'h00AB, 1, 3'd0);
    idle(3'd0);
    chk("s1_commit", 0, 64'(user_dout[0]), 64'h00AB22221111);

    bus(16'h100, 16'h0, 0, 3'd0);
    chk("s2_rd0", 0, 64'(rdata_o[0]), 64'h1111);
    step(0, 16'h0, 16'h0, 16'h0, 0, 0, 3'd0, 40'h0, 1);
    bus(16'h101, 16'h0, 0, 3'd0);
    chk("s2_rd1", 0, 64'(rdata_o[0]), 64'h2222);
    bus(16'h102, 16'h0, 0, 3'd0);
    chk("s2_rd2", 0, 64'(rdata_o[0]), 64'h00AB);
    bus(16'h100, 16'h0, 0, 3'd0);
    chk("s2_fresh", 0, 64'(rdata_o[0]), 64'h0);

    step(0, 16'h120, 16'h0, 16'hBEEF, 0, 1, 3'd0, '0, 0);
    chk("s3_rdata", 0, 64'(rdata_o[0]), 64'hBEEF);
    chk("s3_addr", 0, 64'(addr_o[0]), 64'h120);

    bus(16'h107, 16'h5555, 1, 3'd1);
    bus(16'h107, 16'h0, 0, 3'd1);
    chk("s4_unused", 0, 64'(rdata_o[0]), 64'h0);
    chk("s4_mem1", 0, 64'(user_dout[0]), 64'(init_val[1]));
    bus(16'h104, 16'h1234, 1, 3'd1);
    bus(16'h105, 16'h5678, 1, 3'd1);
    bus(16'h106, 16'h009A, 1, 3'd1);
    idle(3'd1);
    chk("s4_ro", 1, 64'(user_dout[1]), 64'(init_val[1]));
    chk("s4_rw", 0, 64'(user_dout[0]), 64'h9A56781234);

    bus(16'h108, 16'h0, 1, 3'd2);
    bus(16'h109, 16'h0, 1, 3'd2);
    step(0, 16'h10A, 16'h0012, 16'h0, 1, 1, 3'd2, 40'h77, 1);
    idle(3'd2);
    chk("s5_collide", 0, 64'(user_dout[0]), 64'h77);

    bus(16'h100, 16'hAAAA, 1, 3'd0);
    bus(16'h101, 16'hBBBB, 1, 3'd0);
    step(1, 16'h102, 16'h1, 16'h1, 1, 1, 3'd0, '0, 0);
    chk("s6_valid", 0, 64'(valid_o[0]), 64'h0);
    bus(16'h102, 16'h0001, 1, 3'd0);
    idle(3'd0);
    chk("s6_commit", 0, 64'(user_dout[0]), 64'h0100000000);

    for (int n = 0; n < 800; n++) begin
      bit r, uw;
      r  = ($urandom_range(0, 63) == 0);
      uw = !r && ($urandom_range(0, 3) == 0);
      step(r, 16'($urandom_range(16'h0F8, 16'h127)),
           16'($urandom), 16'($urandom),
           1'($urandom), ($urandom_range(0, 4) != 0),
           3'($urandom), {8'($urandom), 32'($urandom)}, uw);
    end
    idle(3'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
